// File: rtl/light_seq_checker.sv
// light_seq_checker
//   Watches the lamp word of a cyclic R->G->Y traffic-light stage and checks
//   encoding, transition order and per-colour dwell time. The first error is
//   latched, and the checker holds in ERROR until clr.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   light[0:2]  lamp word: [0]=R, [1]=G, [2]=Y; registered once before checking
//   clr         synchronous error clear (only acts in ERROR)
//   phase       00 idle/error, 01 red, 10 green, 11 yellow
//   dwell       cycles the current colour has been held (1 on entry)
//   cycle_cnt   completed R->G->Y->R cycles, modulo 256
//   cycle_done  one-cycle pulse when a cycle completes
//   err         sticky error flag
//   err_code    first cause: 01 bad encoding, 10 bad transition, 11 dwell
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for the first valid one-hot lamp word
// S_RED    | red held, counting dwell
// S_GREEN  | green held, counting dwell
// S_YELLOW | yellow held, counting dwell
// S_ERROR  | error latched, outputs frozen until clr
module light_seq_checker #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:2] light,
  input  logic       clr,
  output logic [1:0] phase,
  output logic [7:0] dwell,
  output logic [7:0] cycle_cnt,
  output logic       cycle_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [7:0] MIN_D = 8'(MIN_DWELL);
  localparam logic [7:0] MAX_D = 8'(MAX_DWELL);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_ENC   = 2'b01;
  localparam logic [1:0] CODE_TRANS = 2'b10;
  localparam logic [1:0] CODE_DWELL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_GREEN,
    S_YELLOW,
    S_ERROR
  } state_t;

  state_t     state, state_nxt;
  logic [0:2] light_q;
  logic [7:0] dwell_nxt;
  logic [7:0] cnt_nxt;
  logic       done_nxt;
  logic       err_nxt;
  logic [1:0] code_nxt;
  logic [1:0] cause;

  logic       is_r, is_g, is_y, valid;
  logic       same, legal;
  state_t     colour_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_q <= 3'b000;
    end else begin
      light_q <= light;
    end
  end

  assign is_r  = (light_q == 3'b100);
  assign is_g  = (light_q == 3'b010);
  assign is_y  = (light_q == 3'b001);
  assign valid = is_r | is_g | is_y;

  always_comb begin
    colour_state = S_IDLE;
    if (is_r)      colour_state = S_RED;
    else if (is_g) colour_state = S_GREEN;
    else if (is_y) colour_state = S_YELLOW;
  end

  assign same  = valid && (colour_state == state);
  assign legal = (state == S_RED    && is_g) ||
                 (state == S_GREEN  && is_y) ||
                 (state == S_YELLOW && is_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      dwell      <= 8'd0;
      cycle_cnt  <= 8'd0;
      cycle_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= CODE_NONE;
    end else begin
      state      <= state_nxt;
      dwell      <= dwell_nxt;
      cycle_cnt  <= cnt_nxt;
      cycle_done <= done_nxt;
      err        <= err_nxt;
      err_code   <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    cnt_nxt   = cycle_cnt;
    done_nxt  = 1'b0;
    err_nxt   = err;
    code_nxt  = err_code;
    cause     = CODE_NONE;

    case (state)
      S_IDLE: begin
        // garbage before the first valid word is not an error
        if (valid) begin
          state_nxt = colour_state;
          dwell_nxt = 8'd1;
        end
      end

      S_RED, S_GREEN, S_YELLOW: begin
        // branch order gives the cause priority encoding > transition > dwell
        if (!valid) begin
          cause = CODE_ENC;
        end else if (same) begin
          if (dwell == MAX_D) cause = CODE_DWELL;
          else                dwell_nxt = dwell + 8'd1;
        end else if (legal) begin
          if (dwell < MIN_D) begin
            cause = CODE_DWELL;
          end else begin
            state_nxt = colour_state;
            dwell_nxt = 8'd1;
            if (state == S_YELLOW) begin
              cnt_nxt  = cycle_cnt + 8'd1;
              done_nxt = 1'b1;
            end
          end
        end else begin
          cause = CODE_TRANS;
        end

        // dwell and cycle_cnt stay frozen at their pre-error values
        if (cause != CODE_NONE) begin
          state_nxt = S_ERROR;
          dwell_nxt = dwell;
          cnt_nxt   = cycle_cnt;
          err_nxt   = 1'b1;
          code_nxt  = cause;
        end
      end

      S_ERROR: begin
        if (clr) begin
          state_nxt = S_IDLE;
          dwell_nxt = 8'd0;
          err_nxt   = 1'b0;
          code_nxt  = CODE_NONE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    case (state)
      S_RED:    phase = 2'b01;
      S_GREEN:  phase = 2'b10;
      S_YELLOW: phase = 2'b11;
      default:  phase = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_light_seq_checker.sv
module tb_light_seq_checker;

  logic       clk;
  logic       rst_n;
  logic [0:2] light;
  logic       clr;

  logic [1:0] phase_a, phase_b;
  logic [7:0] dwell_a, dwell_b;
  logic [7:0] cnt_a, cnt_b;
  logic       done_a, done_b;
  logic       err_a, err_b;
  logic [1:0] code_a, code_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int phase;
    int dwell;
    int cnt;
    int done;
    int err;
    int code;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // instance 0: defaults, instance 1: MIN_DWELL=3
  light_seq_checker #(.MIN_DWELL(1), .MAX_DWELL(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .light(light), .clr(clr),
    .phase(phase_a), .dwell(dwell_a), .cycle_cnt(cnt_a),
    .cycle_done(done_a), .err(err_a), .err_code(code_a)
  );

  light_seq_checker #(.MIN_DWELL(3), .MAX_DWELL(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .light(light), .clr(clr),
    .phase(phase_b), .dwell(dwell_b), .cycle_cnt(cnt_b),
    .cycle_done(done_b), .err(err_b), .err_code(code_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference model: one lamp-word pipeline stage, then rule checks
  logic [0:2] m_lq[2];
  bit         m_act[2];
  bit         m_err[2];
  int         m_cur[2];
  int         m_dw[2];
  int         m_cnt[2];
  int         m_done[2];
  int         m_code[2];

  localparam logic [0:2] W_R = 3'b100;
  localparam logic [0:2] W_G = 3'b010;
  localparam logic [0:2] W_Y = 3'b001;
  localparam logic [0:2] W_0 = 3'b000;

  function automatic logic [0:2] col(int i);
    case (i)
      0:       return W_R;
      1:       return W_G;
      default: return W_Y;
    endcase
  endfunction

  function automatic int onehot_idx(logic [0:2] w);
    if (w == W_R) return 0;
    if (w == W_G) return 1;
    if (w == W_Y) return 2;
    return -1;
  endfunction

  function automatic void model_reset(int k);
    m_lq[k]   = W_0;
    m_act[k]  = 0;
    m_err[k]  = 0;
    m_cur[k]  = 0;
    m_dw[k]   = 0;
    m_cnt[k]  = 0;
    m_done[k] = 0;
    m_code[k] = 0;
  endfunction

  function automatic void model_fail(int k, int code);
    m_err[k]  = 1;
    m_code[k] = code;
  endfunction

  function automatic void model_step(int k, int mn, int mx, logic [0:2] l, logic c, logic rn);
    int idx;
    if (!rn) begin
      model_reset(k);
      return;
    end
    idx = onehot_idx(m_lq[k]);
    m_done[k] = 0;
    if (m_err[k]) begin
      if (c) begin
        m_err[k]  = 0;
        m_act[k]  = 0;
        m_dw[k]   = 0;
        m_code[k] = 0;
      end
    end else if (!m_act[k]) begin
      if (idx >= 0) begin
        m_act[k] = 1;
        m_cur[k] = idx;
        m_dw[k]  = 1;
      end
    end else if (idx < 0) begin
      model_fail(k, 1);
    end else if (idx == m_cur[k]) begin
      if (m_dw[k] == mx) model_fail(k, 3);
      else               m_dw[k]++;
    end else if (idx == (m_cur[k] + 1) % 3) begin
      if (m_dw[k] < mn) begin
        model_fail(k, 3);
      end else begin
        if (m_cur[k] == 2) begin
          m_cnt[k]  = (m_cnt[k] + 1) % 256;
          m_done[k] = 1;
        end
        m_cur[k] = idx;
        m_dw[k]  = 1;
      end
    end else begin
      model_fail(k, 2);
    end
    m_lq[k] = l;
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    e.phase = (m_err[k] || !m_act[k]) ? 0 : m_cur[k] + 1;
    e.dwell = m_dw[k];
    e.cnt   = m_cnt[k];
    e.done  = m_done[k];
    e.err   = m_err[k] ? 1 : 0;
    e.code  = m_code[k];
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // monitor: outputs are presented every cycle; compare against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a.phase", int'(phase_a), e.phase);
        check("a.dwell", int'(dwell_a), e.dwell);
        check("a.cycle_cnt", int'(cnt_a), e.cnt);
        check("a.cycle_done", int'(done_a), e.done);
        check("a.err", int'(err_a), e.err);
        check("a.err_code", int'(code_a), e.code);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b.phase", int'(phase_b), e.phase);
        check("b.dwell", int'(dwell_b), e.dwell);
        check("b.cycle_cnt", int'(cnt_b), e.cnt);
        check("b.cycle_done", int'(done_b), e.done);
        check("b.err", int'(err_b), e.err);
        check("b.err_code", int'(code_b), e.code);
      end
    end
  end

  task automatic step(input logic [0:2] l, input logic c, input logic rn);
    @(negedge clk);
    light = l;
    clr   = c;
    rst_n = rn;
    @(posedge clk);
    model_step(0, 1, 16, l, c, rn);
    model_step(1, 3, 16, l, c, rn);
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
  endtask

  task automatic hold(input logic [0:2] l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0, 1'b1);
  endtask

  task automatic recover();
    hold(W_0, 2);
    step(W_0, 1'b1, 1'b1);
    step(W_0, 1'b0, 1'b1);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.a.phase", int'(phase_a), 0);
    check("rst.a.dwell", int'(dwell_a), 0);
    check("rst.a.cycle_cnt", int'(cnt_a), 0);
    check("rst.a.cycle_done", int'(done_a), 0);
    check("rst.a.err", int'(err_a), 0);
    check("rst.a.err_code", int'(code_a), 0);
    check("rst.b.phase", int'(phase_b), 0);
    check("rst.b.dwell", int'(dwell_b), 0);
    check("rst.b.cycle_cnt", int'(cnt_b), 0);
    check("rst.b.err", int'(err_b), 0);
    model_reset(0);
    model_reset(1);
  endtask

  initial begin
    int d;
    int r;
    logic [0:2] w;
    logic c;

    rst_n = 1'b0;
    light = W_0;
    clr   = 1'b0;
    model_reset(0);
    model_reset(1);

    step(W_0, 1'b0, 1'b0);
    step(W_0, 1'b0, 1'b0);
    hold(W_0, 3);
    hold(3'b111, 2);

    // R,G,Y three times, one cycle each
    for (int i = 0; i < 3; i++) begin
      hold(W_R, 1);
      hold(W_G, 1);
      hold(W_Y, 1);
    end
    recover();

    // bad encoding after red
    hold(W_R, 1);
    hold(3'b110, 1);
    hold(W_R, 2);
    recover();

    // illegal R->Y, clear, then red again; clr outside ERROR is ignored
    hold(W_R, 1);
    hold(W_Y, 3);
    step(W_Y, 1'b1, 1'b1);
    hold(W_R, 3);
    step(W_R, 1'b1, 1'b1);
    hold(W_R, 2);
    recover();

    // green held past MAX_DWELL
    hold(W_G, 20);
    recover();

    // MIN_DWELL boundary: two reds then green, then three reds then green
    hold(W_R, 2);
    hold(W_G, 2);
    recover();
    hold(W_R, 3);
    hold(W_G, 3);
    hold(W_Y, 3);
    hold(W_R, 1);
    recover();

    // randomized walk with occasional faults and clears
    d = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      c = 1'b0;
      if (r < 55) begin
        w = col(d);
      end else if (r < 85) begin
        d = (d + 1) % 3;
        w = col(d);
      end else if (r < 89) begin
        w = 3'($urandom_range(0, 7));
      end else if (r < 93) begin
        d = (d + 2) % 3;
        w = col(d);
      end else begin
        w = col(d);
        c = 1'b1;
      end
      step(w, c, 1'b1);
    end

    // 256 full cycles from reset so cycle_cnt wraps to 0
    step(W_0, 1'b0, 1'b0);
    step(W_0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      hold(W_R, 3);
      hold(W_G, 3);
      hold(W_Y, 3);
    end
    hold(W_R, 3);
    hold(W_G, 2);

    // asynchronous reset mid-green
    async_reset_check();
    step(W_G, 1'b0, 1'b0);
    step(W_R, 1'b0, 1'b1);
    hold(W_R, 2);
    hold(W_G, 2);

    repeat (2) @(negedge clk);
    #1;
    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
